// File: rtl/out_port_ctrl.sv
// Output-port controller: buffers OUT writes in a circular FIFO behind a
// registered O_Port with a valid/ready handshake, stall on full, sticky overflow.
module out_port_ctrl #(
   parameter int DATA_W = 8,
   parameter int DEPTH  = 4,
   parameter int LVL_W  = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              out_we,
   input  logic [DATA_W-1:0] out_data,
   output logic              stall_req,
   output logic [DATA_W-1:0] O_Port,
   output logic              o_valid,
   input  logic              o_ready,
   output logic [LVL_W-1:0]  level,
   output logic              overflow,
   input  logic              ovf_clr
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [PTR_W-1:0]  wptr_q, wptr_d;
   logic [PTR_W-1:0]  rptr_q, rptr_d;
   logic [LVL_W-1:0]  count_q, count_d;
   logic [DATA_W-1:0] oport_q, oport_d;
   logic              ovld_q, ovld_d;
   logic              ovf_q, ovf_d;

   logic hs, empty, full, bypass, pop, direct, push_req, push, drop;

   always_comb begin
      hs       = ovld_q & o_ready;
      empty    = (count_q == '0);
      full     = (count_q == LVL_W'(DEPTH));
      bypass   = ~ovld_q & empty & out_we;
      pop      = hs & ~empty;
      direct   = hs & empty & out_we;
      push_req = out_we & ~bypass & ~direct;
      // A full FIFO still accepts a write when the head leaves on the same edge.
      push     = push_req & (~full | pop);
      drop     = push_req & full & ~pop;
   end

   always_comb begin
      oport_d = oport_q;
      ovld_d  = ovld_q;
      if (bypass) begin
         oport_d = out_data;
         ovld_d  = 1'b1;
      end else if (pop) begin
         oport_d = mem_q[rptr_q];
      end else if (direct) begin
         oport_d = out_data;
      end else if (hs) begin
         ovld_d  = 1'b0;
      end
   end

   always_comb begin
      wptr_d  = push ? wptr_q + 1'b1 : wptr_q;
      rptr_d  = pop  ? rptr_q + 1'b1 : rptr_q;
      count_d = count_q;
      case ({push, pop})
         2'b10:   count_d = count_q + LVL_W'(1);
         2'b01:   count_d = count_q - LVL_W'(1);
         default: count_d = count_q;
      endcase
      ovf_d = drop ? 1'b1 : (ovf_clr ? 1'b0 : ovf_q);
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wptr_q  <= '0;
         rptr_q  <= '0;
         count_q <= '0;
         oport_q <= '0;
         ovld_q  <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
         count_q <= count_d;
         oport_q <= oport_d;
         ovld_q  <= ovld_d;
         ovf_q   <= ovf_d;
      end
   end

   // Storage array carries data only; its contents are qualified by count_q.
   always_ff @(posedge clk) begin
      if (push) mem_q[wptr_q] <= out_data;
   end

   assign stall_req = full;
   assign O_Port    = oport_q;
   assign o_valid   = ovld_q;
   assign level     = count_q;
   assign overflow  = ovf_q;

endmodule

// File: tb/tb_out_port_ctrl.sv
// Scoreboard bench for out_port_ctrl: directed writes push expected words,
// a negedge monitor pops and compares on every accepted word.
module tb_out_port_ctrl;

   logic       clk = 1'b0;
   logic       rstn = 1'b0;
   logic       out_we = 1'b0;
   logic [7:0] out_data = 8'h00;
   logic       stall_req;
   logic [7:0] O_Port;
   logic       o_valid;
   logic       o_ready = 1'b0;
   logic [2:0] level;
   logic       overflow;
   logic       ovf_clr = 1'b0;

   int total = 0;
   int bad   = 0;
   logic [7:0] exp_q [$];

   out_port_ctrl #(.DATA_W(8), .DEPTH(4), .LVL_W(3)) dut (
      .clk(clk), .rstn(rstn), .out_we(out_we), .out_data(out_data),
      .stall_req(stall_req), .O_Port(O_Port), .o_valid(o_valid),
      .o_ready(o_ready), .level(level), .overflow(overflow), .ovf_clr(ovf_clr)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Monitor: every edge with o_valid && o_ready retires the scoreboard head.
   always @(negedge clk) begin
      if (rstn && o_valid && o_ready) begin
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL word_extra: got %0h expected none", O_Port);
         end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            if (O_Port !== e) begin
               bad++;
               $display("FAIL word_order: got %0h expected %0h", O_Port, e);
            end
         end
      end
   end

   task automatic wr(input logic [7:0] d, input bit keep);
      out_we   = 1'b1;
      out_data = d;
      if (keep) exp_q.push_back(d);
      @(posedge clk); #1;
      out_we = 1'b0;
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      // reset state
      o_ready = 1'b1;
      step(2);
      chk("rst_oport", O_Port, 8'h00);
      chk("rst_valid", {7'd0, o_valid}, 8'd0);
      chk("rst_level", {5'd0, level}, 8'd0);
      chk("rst_stall", {7'd0, stall_req}, 8'd0);
      chk("rst_ovf", {7'd0, overflow}, 8'd0);
      rstn = 1'b1;
      step(1);

      // idle single write
      wr(8'h55, 1'b1);
      chk("idle_valid", {7'd0, o_valid}, 8'd1);
      chk("idle_oport", O_Port, 8'h55);
      step(1);
      chk("idle_valid_drop", {7'd0, o_valid}, 8'd0);
      chk("idle_oport_hold", O_Port, 8'h55);
      chk("idle_level", {5'd0, level}, 8'd0);

      // backpressure fill
      o_ready = 1'b0;
      wr(8'h11, 1'b1); wr(8'h22, 1'b1); wr(8'h33, 1'b1);
      wr(8'h44, 1'b1); wr(8'h55, 1'b1);
      chk("fill_oport", O_Port, 8'h11);
      chk("fill_level", {5'd0, level}, 8'd4);
      chk("fill_stall", {7'd0, stall_req}, 8'd1);
      chk("fill_ovf", {7'd0, overflow}, 8'd0);

      // overflow while full, then drain
      wr(8'h66, 1'b0);
      chk("ovf_set", {7'd0, overflow}, 8'd1);
      chk("ovf_level", {5'd0, level}, 8'd4);
      chk("ovf_oport_hold", O_Port, 8'h11);
      o_ready = 1'b1;
      step(1);
      chk("stall_fall", {7'd0, stall_req}, 8'd0);
      chk("drain_level", {5'd0, level}, 8'd3);
      step(6);
      chk("drain_valid", {7'd0, o_valid}, 8'd0);
      chk("drain_empty", {5'd0, level}, 8'd0);
      chk("ovf_sticky", {7'd0, overflow}, 8'd1);
      ovf_clr = 1'b1;
      step(1);
      ovf_clr = 1'b0;
      chk("ovf_clr", {7'd0, overflow}, 8'd0);

      // full with simultaneous pop, pointers wrap
      o_ready = 1'b0;
      wr(8'hA1, 1'b1); wr(8'hA2, 1'b1); wr(8'hA3, 1'b1);
      wr(8'hA4, 1'b1); wr(8'hA5, 1'b1);
      chk("full2_level", {5'd0, level}, 8'd4);
      o_ready = 1'b1;
      wr(8'h77, 1'b1);
      chk("fullpop_ovf", {7'd0, overflow}, 8'd0);
      chk("fullpop_level", {5'd0, level}, 8'd4);
      chk("fullpop_oport", O_Port, 8'hA2);
      step(8);
      chk("fullpop_drained", {7'd0, o_valid}, 8'd0);

      // streaming at one word per cycle
      for (int i = 1; i <= 8; i++) begin
         wr(8'(i), 1'b1);
         chk("stream_level", {5'd0, level}, 8'd0);
         chk("stream_stall", {7'd0, stall_req}, 8'd0);
         chk("stream_oport", O_Port, 8'(i));
      end
      step(2);
      chk("stream_idle", {7'd0, o_valid}, 8'd0);

      // reset mid-operation discards buffered words
      o_ready = 1'b0;
      wr(8'hB1, 1'b1); wr(8'hB2, 1'b1); wr(8'hB3, 1'b1); wr(8'hB4, 1'b1);
      chk("mid_level", {5'd0, level}, 8'd3);
      exp_q.delete();
      rstn = 1'b0;
      #1;
      chk("mid_rst_oport", O_Port, 8'h00);
      chk("mid_rst_valid", {7'd0, o_valid}, 8'd0);
      chk("mid_rst_level", {5'd0, level}, 8'd0);
      chk("mid_rst_stall", {7'd0, stall_req}, 8'd0);
      step(1);
      rstn = 1'b1;
      o_ready = 1'b1;
      step(1);
      wr(8'hA5, 1'b1);
      chk("post_rst_valid", {7'd0, o_valid}, 8'd1);
      chk("post_rst_oport", O_Port, 8'hA5);
      step(3);
      chk("sb_empty", 8'(exp_q.size()), 8'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
